// File: rtl/axis_stream_fifo.sv
// axis_stream_fifo: parametrised AXI-Stream FIFO with TLAST sideband,
// optional store-and-forward, fill-level flags and synchronous flush.
module axis_stream_fifo #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 8,
  parameter bit PACKET_MODE = 1'b0,
  parameter int AF_THRESH   = DEPTH - 1,
  parameter int AE_THRESH   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       s_tvalid,
  input  logic [DATA_W-1:0]          s_tdata,
  input  logic                       s_tlast,
  output logic                       s_tready,
  output logic                       m_tvalid,
  output logic [DATA_W-1:0]          m_tdata,
  output logic                       m_tlast,
  input  logic                       m_tready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] pkt_count
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] L_DEPTH = LW'(DEPTH);
  localparam logic [PW-1:0] P_LAST  = PW'(DEPTH - 1);

  logic [DATA_W:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [LW-1:0]   r_level;
  logic [LW-1:0]   r_pkt;

  logic            w_full;
  logic            w_empty;
  logic            w_s_tready;
  logic            w_m_tvalid;
  logic            w_wr;
  logic            w_rd;
  logic [DATA_W:0] w_head;
  logic            w_pkt_inc;
  logic            w_pkt_dec;
  logic [PW-1:0]   w_wptr_nxt;
  logic [PW-1:0]   w_rptr_nxt;
  logic [LW-1:0]   w_level_nxt;
  logic [LW-1:0]   w_pkt_nxt;

  assign w_full  = (r_level == L_DEPTH);
  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rptr];

  // Handshake qualifiers; flush blocks both sides, packet mode
  // holds output until a whole packet is stored or FIFO is full.
  always_comb begin
    w_s_tready = !flush && !w_full;
    w_m_tvalid = !flush && !w_empty;
    if (PACKET_MODE) begin
      w_m_tvalid = w_m_tvalid && ((r_pkt != '0) || w_full);
    end
  end

  assign w_wr      = s_tvalid && w_s_tready;
  assign w_rd      = w_m_tvalid && m_tready;
  assign w_pkt_inc = w_wr && s_tlast;
  assign w_pkt_dec = w_rd && w_head[DATA_W];

  // Explicit pointer wrap so any DEPTH works.
  always_comb begin
    w_wptr_nxt = r_wptr;
    w_rptr_nxt = r_rptr;
    if (w_wr) begin
      w_wptr_nxt = (r_wptr == P_LAST) ? '0 : r_wptr + 1'b1;
    end
    if (w_rd) begin
      w_rptr_nxt = (r_rptr == P_LAST) ? '0 : r_rptr + 1'b1;
    end
  end

  // Level and packet counters; simultaneous +1/-1 cancel.
  always_comb begin
    w_level_nxt = r_level;
    w_pkt_nxt   = r_pkt;
    unique case ({w_wr, w_rd})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
    unique case ({w_pkt_inc, w_pkt_dec})
      2'b10:   w_pkt_nxt = r_pkt + 1'b1;
      2'b01:   w_pkt_nxt = r_pkt - 1'b1;
      default: w_pkt_nxt = r_pkt;
    endcase
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= {s_tlast, s_tdata};
    end
  end

  // Pointer and counter state with async reset and sync flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_pkt   <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_pkt   <= '0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_level <= w_level_nxt;
      r_pkt   <= w_pkt_nxt;
    end
  end

  assign s_tready     = w_s_tready;
  assign m_tvalid     = w_m_tvalid;
  assign m_tdata      = w_head[DATA_W-1:0];
  assign m_tlast      = w_head[DATA_W];
  assign level        = r_level;
  assign pkt_count    = r_pkt;
  assign almost_full  = (int'(r_level) >= AF_THRESH);
  assign almost_empty = (int'(r_level) <= AE_THRESH);

endmodule

// File: tb/tb_axis_stream_fifo.sv
// tb_axis_stream_fifo: scoreboard bench for axis_stream_fifo
// across streaming, packet and oversize-packet configurations.
module tb_axis_stream_fifo;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: DATA_W=16, DEPTH=6, streaming
  logic        a_flush = 0, a_s_tvalid = 0, a_s_tlast = 0, a_m_tready = 0;
  logic [15:0] a_s_tdata = '0;
  logic        a_s_tready, a_m_tvalid, a_m_tlast, a_af, a_ae;
  logic [15:0] a_m_tdata;
  logic [2:0]  a_level, a_pkt;

  // Instance P: DATA_W=8, DEPTH=8, packet mode
  logic        p_flush = 0, p_s_tvalid = 0, p_s_tlast = 0, p_m_tready = 0;
  logic [7:0]  p_s_tdata = '0;
  logic        p_s_tready, p_m_tvalid, p_m_tlast, p_af, p_ae;
  logic [7:0]  p_m_tdata;
  logic [3:0]  p_level, p_pkt;

  // Instance O: DATA_W=8, DEPTH=4, packet mode
  logic        o_flush = 0, o_s_tvalid = 0, o_s_tlast = 0, o_m_tready = 0;
  logic [7:0]  o_s_tdata = '0;
  logic        o_s_tready, o_m_tvalid, o_m_tlast, o_af, o_ae;
  logic [7:0]  o_m_tdata;
  logic [2:0]  o_level, o_pkt;

  axis_stream_fifo #(.DATA_W(16), .DEPTH(6), .PACKET_MODE(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .s_tvalid(a_s_tvalid), .s_tdata(a_s_tdata), .s_tlast(a_s_tlast),
    .s_tready(a_s_tready), .m_tvalid(a_m_tvalid), .m_tdata(a_m_tdata),
    .m_tlast(a_m_tlast), .m_tready(a_m_tready), .level(a_level),
    .almost_full(a_af), .almost_empty(a_ae), .pkt_count(a_pkt));

  axis_stream_fifo #(.DATA_W(8), .DEPTH(8), .PACKET_MODE(1'b1)) u_p (
    .clk(clk), .rst_n(rst_n), .flush(p_flush),
    .s_tvalid(p_s_tvalid), .s_tdata(p_s_tdata), .s_tlast(p_s_tlast),
    .s_tready(p_s_tready), .m_tvalid(p_m_tvalid), .m_tdata(p_m_tdata),
    .m_tlast(p_m_tlast), .m_tready(p_m_tready), .level(p_level),
    .almost_full(p_af), .almost_empty(p_ae), .pkt_count(p_pkt));

  axis_stream_fifo #(.DATA_W(8), .DEPTH(4), .PACKET_MODE(1'b1)) u_o (
    .clk(clk), .rst_n(rst_n), .flush(o_flush),
    .s_tvalid(o_s_tvalid), .s_tdata(o_s_tdata), .s_tlast(o_s_tlast),
    .s_tready(o_s_tready), .m_tvalid(o_m_tvalid), .m_tdata(o_m_tdata),
    .m_tlast(o_m_tlast), .m_tready(o_m_tready), .level(o_level),
    .almost_full(o_af), .almost_empty(o_ae), .pkt_count(o_pkt));

  logic [16:0] qa[$];
  logic [8:0]  qp[$];
  logic [8:0]  qo[$];

  task automatic cyc_a(input logic v, input logic [15:0] d, input logic l,
                       input logic rdy, input logic fl,
                       output logic wr, output logic rd);
    @(negedge clk);
    a_s_tvalid = v; a_s_tdata = d; a_s_tlast = l;
    a_m_tready = rdy; a_flush = fl;
    #1;
    wr = a_s_tvalid & a_s_tready;
    rd = a_m_tvalid & a_m_tready;
  endtask

  task automatic cyc_p(input logic v, input logic [7:0] d, input logic l,
                       input logic rdy, output logic wr, output logic rd);
    @(negedge clk);
    p_s_tvalid = v; p_s_tdata = d; p_s_tlast = l; p_m_tready = rdy;
    #1;
    wr = p_s_tvalid & p_s_tready;
    rd = p_m_tvalid & p_m_tready;
  endtask

  task automatic cyc_o(input logic v, input logic [7:0] d, input logic l,
                       input logic rdy, output logic wr, output logic rd);
    @(negedge clk);
    o_s_tvalid = v; o_s_tdata = d; o_s_tlast = l; o_m_tready = rdy;
    #1;
    wr = o_s_tvalid & o_s_tready;
    rd = o_m_tvalid & o_m_tready;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (a_s_tready !== 1'b1) begin
      errors++; $display("FAIL rst_s_tready: got %b expected 1", a_s_tready);
    end
    checks++;
    if (a_m_tvalid !== 1'b0) begin
      errors++; $display("FAIL rst_m_tvalid: got %b expected 0", a_m_tvalid);
    end
    checks++;
    if (a_level !== 3'd0) begin
      errors++; $display("FAIL rst_level: got %0d expected 0", a_level);
    end
    checks++;
    if (a_ae !== 1'b1 || a_af !== 1'b0) begin
      errors++; $display("FAIL rst_flags: got ae=%b af=%b expected ae=1 af=0", a_ae, a_af);
    end
    checks++;
    if (a_pkt !== 3'd0 || p_pkt !== 4'd0) begin
      errors++; $display("FAIL rst_pkt: got %0d/%0d expected 0/0", a_pkt, p_pkt);
    end
    checks++;
    if (p_m_tvalid !== 1'b0 || o_m_tvalid !== 1'b0) begin
      errors++; $display("FAIL rst_pm_tvalid: got %b/%b expected 0/0", p_m_tvalid, o_m_tvalid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic wr, rd;
    logic [15:0] d;
    logic [16:0] exp;
    int nw = 0;
    int nr = 0;
    for (int i = 0; i < 7; i++) begin
      d = 16'h1000 + 16'(i);
      cyc_a(1'b1, d, 1'b0, 1'b0, 1'b0, wr, rd);
      if (i == 0) begin
        checks++;
        if (a_m_tvalid !== 1'b0) begin
          errors++; $display("FAIL fill_no_passthru: got %b expected 0", a_m_tvalid);
        end
      end
      if (wr) begin qa.push_back({1'b0, d}); nw++; end
    end
    checks++;
    if (nw !== 6) begin
      errors++; $display("FAIL fill_count: got %0d expected 6", nw);
    end
    checks++;
    if (a_s_tready !== 1'b0) begin
      errors++; $display("FAIL full_s_tready: got %b expected 0", a_s_tready);
    end
    checks++;
    if (a_level !== 3'd6 || a_af !== 1'b1) begin
      errors++; $display("FAIL full_level: got %0d af=%b expected 6 af=1", a_level, a_af);
    end
    for (int k = 0; k < 20 && qa.size() > 0; k++) begin
      cyc_a(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, wr, rd);
      if (rd) begin
        exp = qa.pop_front(); nr++; checks++;
        if ({a_m_tlast, a_m_tdata} !== exp) begin
          errors++; $display("FAIL drain_data: got %h expected %h", {a_m_tlast, a_m_tdata}, exp);
        end
      end
    end
    checks++;
    if (nr !== 6) begin
      errors++; $display("FAIL drain_count: got %0d expected 6", nr);
    end
    cyc_a(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, wr, rd);
    checks++;
    if (a_level !== 3'd0 || a_ae !== 1'b1) begin
      errors++; $display("FAIL drain_level: got %0d ae=%b expected 0 ae=1", a_level, a_ae);
    end
  endtask

  task automatic test_wrap();
    logic wr, rd;
    logic [15:0] d;
    logic [16:0] exp;
    int nr = 0;
    qa.delete();
    for (int i = 0; i < 3; i++) begin
      d = 16'h3000 + 16'(i);
      cyc_a(1'b1, d, 1'b0, 1'b0, 1'b0, wr, rd);
      if (wr) qa.push_back({1'b0, d});
    end
    for (int i = 0; i < 20; i++) begin
      d = 16'h3100 + 16'(i);
      cyc_a(1'b1, d, i[0], 1'b1, 1'b0, wr, rd);
      checks++;
      if (a_level !== 3'd3) begin
        errors++; $display("FAIL wrap_level: got %0d expected 3", a_level);
      end
      if (rd) begin
        exp = qa.pop_front(); nr++; checks++;
        if ({a_m_tlast, a_m_tdata} !== exp) begin
          errors++; $display("FAIL wrap_data: got %h expected %h", {a_m_tlast, a_m_tdata}, exp);
        end
      end
      if (wr) qa.push_back({i[0], d});
    end
    checks++;
    if (nr !== 20) begin
      errors++; $display("FAIL wrap_reads: got %0d expected 20", nr);
    end
    for (int k = 0; k < 20 && qa.size() > 0; k++) begin
      cyc_a(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, wr, rd);
      if (rd) begin
        exp = qa.pop_front(); checks++;
        if ({a_m_tlast, a_m_tdata} !== exp) begin
          errors++; $display("FAIL wrap_tail: got %h expected %h", {a_m_tlast, a_m_tdata}, exp);
        end
      end
    end
    cyc_a(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, wr, rd);
    checks++;
    if (a_level !== 3'd0 || a_pkt !== 3'd0) begin
      errors++; $display("FAIL wrap_end: got lvl=%0d pkt=%0d expected 0/0", a_level, a_pkt);
    end
  endtask

  task automatic test_flush();
    logic wr, rd;
    logic [15:0] d;
    for (int i = 0; i < 5; i++) begin
      d = 16'h4000 + 16'(i);
      cyc_a(1'b1, d, (i == 1), 1'b0, 1'b0, wr, rd);
    end
    cyc_a(1'b1, 16'h4444, 1'b1, 1'b1, 1'b1, wr, rd);
    checks++;
    if (a_level !== 3'd5 || a_pkt !== 3'd1) begin
      errors++; $display("FAIL preflush: got lvl=%0d pkt=%0d expected 5/1", a_level, a_pkt);
    end
    checks++;
    if (wr !== 1'b0 || rd !== 1'b0) begin
      errors++; $display("FAIL flush_hs: got wr=%b rd=%b expected 0/0", wr, rd);
    end
    cyc_a(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, wr, rd);
    checks++;
    if (a_level !== 3'd0 || a_pkt !== 3'd0) begin
      errors++; $display("FAIL postflush: got lvl=%0d pkt=%0d expected 0/0", a_level, a_pkt);
    end
    cyc_a(1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, wr, rd);
    checks++;
    if (rd !== 1'b0 || wr !== 1'b1) begin
      errors++; $display("FAIL flush_wr: got wr=%b rd=%b expected 1/0", wr, rd);
    end
    cyc_a(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, wr, rd);
    checks++;
    if (rd !== 1'b1 || a_m_tdata !== 16'h2222) begin
      errors++; $display("FAIL flush_first: got rd=%b data=%h expected 1/2222", rd, a_m_tdata);
    end
    cyc_a(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, wr, rd);
  endtask

  task automatic test_packet();
    logic wr, rd;
    logic [7:0] d;
    logic [8:0] exp;
    int nr = 0;
    for (int i = 0; i < 3; i++) begin
      d = 8'h60 + 8'(i);
      cyc_p(1'b1, d, (i == 2), 1'b1, wr, rd);
      checks++;
      if (p_m_tvalid !== 1'b0) begin
        errors++; $display("FAIL pkt_hold: beat %0d got %b expected 0", i, p_m_tvalid);
      end
      if (wr) qp.push_back({(i == 2), d});
    end
    for (int k = 0; k < 10 && qp.size() > 0; k++) begin
      cyc_p(1'b0, 8'h0, 1'b0, 1'b1, wr, rd);
      if (k == 0) begin
        checks++;
        if (p_m_tvalid !== 1'b1) begin
          errors++; $display("FAIL pkt_release: got %b expected 1", p_m_tvalid);
        end
      end
      if (rd) begin
        exp = qp.pop_front(); nr++; checks++;
        if ({p_m_tlast, p_m_tdata} !== exp || p_pkt !== 4'd1) begin
          errors++; $display("FAIL pkt_data: got %h pkt=%0d expected %h pkt=1", {p_m_tlast, p_m_tdata}, p_pkt, exp);
        end
      end
    end
    checks++;
    if (nr !== 3) begin
      errors++; $display("FAIL pkt_count_rd: got %0d expected 3", nr);
    end
    cyc_p(1'b0, 8'h0, 1'b0, 1'b0, wr, rd);
    checks++;
    if (p_pkt !== 4'd0 || p_level !== 4'd0) begin
      errors++; $display("FAIL pkt_end: got pkt=%0d lvl=%0d expected 0/0", p_pkt, p_level);
    end
  endtask

  task automatic test_oversize();
    logic wr, rd;
    logic [7:0] d;
    logic [8:0] exp;
    int sent = 0;
    int nr = 0;
    bit seen4 = 0;
    for (int k = 0; k < 40 && (sent < 6 || qo.size() > 0); k++) begin
      d = 8'h50 + 8'(sent);
      cyc_o(sent < 6, d, (sent == 5), 1'b1, wr, rd);
      if (o_level == 3'd4 && !seen4) begin
        seen4 = 1; checks++;
        if (o_m_tvalid !== 1'b1) begin
          errors++; $display("FAIL ovr_full_valid: got %b expected 1", o_m_tvalid);
        end
      end
      if (o_level != 3'd0 && o_level < 3'd4 && o_pkt == 3'd0) begin
        checks++;
        if (o_m_tvalid !== 1'b0) begin
          errors++; $display("FAIL ovr_hold: lvl=%0d got %b expected 0", o_level, o_m_tvalid);
        end
      end
      if (rd) begin
        exp = qo.pop_front(); nr++; checks++;
        if ({o_m_tlast, o_m_tdata} !== exp) begin
          errors++; $display("FAIL ovr_data: got %h expected %h", {o_m_tlast, o_m_tdata}, exp);
        end
      end
      if (wr) begin qo.push_back({(sent == 5), d}); sent++; end
    end
    checks++;
    if (nr !== 6 || !seen4) begin
      errors++; $display("FAIL ovr_done: got reads=%0d seen4=%0d expected 6/1", nr, seen4);
    end
    cyc_o(1'b0, 8'h0, 1'b0, 1'b0, wr, rd);
  endtask

  task automatic test_async_reset();
    logic wr, rd;
    for (int i = 0; i < 4; i++) begin
      cyc_a(1'b1, 16'h7000 + 16'(i), 1'b0, 1'b0, 1'b0, wr, rd);
    end
    cyc_a(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, wr, rd);
    checks++;
    if (a_level !== 3'd4) begin
      errors++; $display("FAIL ar_pre: got %0d expected 4", a_level);
    end
    a_m_tready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_m_tvalid !== 1'b0 || a_s_tready !== 1'b1) begin
      errors++; $display("FAIL ar_hs: got mv=%b sr=%b expected 0/1", a_m_tvalid, a_s_tready);
    end
    checks++;
    if (a_level !== 3'd0 || a_ae !== 1'b1) begin
      errors++; $display("FAIL ar_level: got %0d ae=%b expected 0 ae=1", a_level, a_ae);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc_a(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, wr, rd);
    checks++;
    if (a_level !== 3'd0 || a_m_tvalid !== 1'b0) begin
      errors++; $display("FAIL ar_post: got lvl=%0d mv=%b expected 0/0", a_level, a_m_tvalid);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_flush();
    test_packet();
    test_oversize();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
